// File: rtl/demux_feed_sequencer.sv
// demux_feed_sequencer
// Buffers 4-bit words from a valid/ready producer in a small FIFO and
// dispatches them to a 1-to-2 demux as (x_out, c_out). Words are sent in
// fixed-length bursts that alternate between channel A (0) and channel B (1).
// A stalled channel holds the sequence; the other channel is never used
// out of turn.

module demux_feed_sequencer #(
    parameter int DEPTH = 4,
    parameter int BURST = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   ready_a,
    input  logic                   ready_b,
    output logic [3:0]             x_out,
    output logic                   c_out,
    output logic                   out_valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [3:0]  BURST_LAST = 4'(BURST - 1);

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_t;

    chan_t         chan;
    logic [3:0]    bcnt;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push;
    logic          disp;
    logic          chan_ready;

    // Room is judged on the registered fill level only, so a dispatch in the
    // same cycle never frees a slot for the producer until the next cycle.
    assign in_ready   = (count < FULL_LEVEL);
    assign chan_ready = (chan == CH_A) ? ready_a : ready_b;
    assign push       = in_valid & in_ready;
    assign disp       = (count != '0) & chan_ready;

    // Storage array; contents need no reset because the pointers and the
    // fill level decide what is ever read out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    // Write/read pointers wrap naturally at the power-of-two depth; the fill
    // level moves only when exactly one of push/dispatch happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (disp) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, disp})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Channel FSM with burst counter and registered demux-side outputs;
    // without a dispatch the data bus is zeroed and the select is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan      <= CH_A;
            bcnt      <= '0;
            x_out     <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else if (disp) begin
            x_out     <= mem[rptr];
            c_out     <= chan;
            out_valid <= 1'b1;
            if (bcnt == BURST_LAST) begin
                bcnt <= '0;
                case (chan)
                    CH_A:    chan <= CH_B;
                    default: chan <= CH_A;
                endcase
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end else begin
            x_out     <= '0;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux_feed_sequencer.sv
// Testbench for demux_feed_sequencer: a queue scoreboard receives each word
// as it is offered and accepted, and is popped when the channel model says a
// dispatch is due; scenario tasks add fixed expectations for key cycles.

module tb_demux_feed_sequencer;

    localparam int DEPTH = 4;
    localparam int BURST = 2;

    logic       clk;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ready_a;
    logic       ready_b;
    logic [3:0] x_out;
    logic       c_out;
    logic       out_valid;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    logic [3:0] q[$];
    logic       m_chan;
    int         m_bcnt;
    logic       exp_valid;
    logic [3:0] exp_x;
    logic       exp_c;
    logic [9:0] obs;
    logic [9:0] want;

    demux_feed_sequencer #(.DEPTH(DEPTH), .BURST(BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ready_a   (ready_a),
        .ready_b   (ready_b),
        .x_out     (x_out),
        .c_out     (c_out),
        .out_valid (out_valid),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard and channel model back to their reset state
    task automatic model_reset();
        q.delete();
        m_chan    = 1'b0;
        m_bcnt    = 0;
        exp_valid = 1'b0;
        exp_x     = 4'h0;
        exp_c     = 1'b0;
    endtask

    // One clock: predict from pre-edge inputs, then sample #1 after the edge
    task automatic cycle();
        logic p;
        logic d;
        p = in_valid && (q.size() < DEPTH);
        d = (q.size() > 0) && (m_chan ? ready_b : ready_a);
        if (d) begin
            exp_x     = q.pop_front();
            exp_c     = m_chan;
            exp_valid = 1'b1;
            if (m_bcnt == BURST - 1) begin
                m_bcnt = 0;
                m_chan = ~m_chan;
            end else begin
                m_bcnt++;
            end
        end else begin
            exp_valid = 1'b0;
            exp_x     = 4'h0;
        end
        if (p) q.push_back(in_data);
        @(posedge clk);
        #1;
        obs  = {out_valid, x_out, c_out, count, in_ready};
        want = {exp_valid, exp_x, exp_c, 3'(q.size()), q.size() < DEPTH};
    endtask

    // Reset pulse spanning one edge, released mid-cycle
    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        in_valid = 1'b0;
        ready_a  = 1'b0;
        ready_b  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = 4'h0; ready_a = 1'b0; ready_b = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, x_out, c_out, count, in_ready} !== {1'b0, 4'h0, 1'b0, 3'd0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL reset_async got=%h want=%h", {out_valid, x_out, c_out, count, in_ready}, {1'b0, 4'h0, 1'b0, 3'd0, 1'b1});
        end
        model_reset();
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || count !== 3'd0) begin
            bad++;
            $display("[TB] FAIL reset_hold got in_ready=%b count=%0d want in_ready=1 count=0", in_ready, count);
        end
        @(negedge clk);
        rst = 1'b0;
        cycle();
        total++;
        if (obs !== want) begin
            bad++;
            $display("[TB] FAIL reset_release got=%h want=%h", obs, want);
        end
    endtask

    task automatic test_burst();
        logic [3:0] xs [5];
        logic       cs [5];
        xs = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        cs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        ready_a = 1'b1;
        ready_b = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 5);
            in_data  = 4'(i + 1);
            cycle();
            total++;
            if (obs !== want) begin
                bad++;
                $display("[TB] FAIL burst_model cyc%0d got=%h want=%h", i, obs, want);
            end
            total++;
            if (i >= 1 && i <= 5) begin
                if (out_valid !== 1'b1 || x_out !== xs[i-1] || c_out !== cs[i-1]) begin
                    bad++;
                    $display("[TB] FAIL burst_word cyc%0d got v=%b x=%h c=%b want v=1 x=%h c=%b", i, out_valid, x_out, c_out, xs[i-1], cs[i-1]);
                end
            end else if (out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL burst_idle cyc%0d got v=%b want v=0", i, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full();
        logic [3:0] xs [3];
        logic       cs [3];
        xs = '{4'h8, 4'h9, 4'hA};
        cs = '{1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(6 + i);
            cycle();
            total++;
            if (obs !== want) begin
                bad++;
                $display("[TB] FAIL full_fill cyc%0d got=%h want=%h", i, obs, want);
            end
        end
        total++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_level got count=%0d in_ready=%b want count=4 in_ready=0", count, in_ready);
        end
        in_data = 4'hA;
        cycle();
        total++;
        if (count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b0 || obs !== want) begin
            bad++;
            $display("[TB] FAIL full_hold got=%h want=%h", obs, want);
        end
        ready_a = 1'b1;
        ready_b = 1'b1;
        cycle();
        total++;
        if ({out_valid, x_out, c_out, count, in_ready} !== {1'b1, 4'h6, 1'b0, 3'd3, 1'b1} || obs !== want) begin
            bad++;
            $display("[TB] FAIL full_first_drain got=%h want=%h", obs, {1'b1, 4'h6, 1'b0, 3'd3, 1'b1});
        end
        cycle();
        in_valid = 1'b0;
        total++;
        if ({out_valid, x_out, c_out, count} !== {1'b1, 4'h7, 1'b0, 3'd3} || obs !== want) begin
            bad++;
            $display("[TB] FAIL full_late_accept got=%h want=%h", obs, want);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (obs !== want || out_valid !== 1'b1 || x_out !== xs[i] || c_out !== cs[i]) begin
                bad++;
                $display("[TB] FAIL full_drain%0d got v=%b x=%h c=%b want v=1 x=%h c=%b", i, out_valid, x_out, c_out, xs[i], cs[i]);
            end
        end
        cycle();
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_empty got count=%0d v=%b want count=0 v=0", count, out_valid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i + 1);
            cycle();
        end
        in_valid = 1'b0;
        ready_a  = 1'b1;
        ready_b  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++;
            if (obs !== want || x_out !== 4'(i + 1) || c_out !== 1'b0 || out_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL stall_to_a%0d got=%h want=%h", i, obs, want);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (obs !== want || out_valid !== 1'b0 || x_out !== 4'h0 || count !== 3'd2) begin
                bad++;
                $display("[TB] FAIL stall_hold%0d got v=%b x=%h count=%0d want v=0 x=0 count=2", i, out_valid, x_out, count);
            end
        end
        ready_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++;
            if (obs !== want || out_valid !== 1'b1 || x_out !== 4'(i + 3) || c_out !== 1'b1) begin
                bad++;
                $display("[TB] FAIL stall_resume%0d got v=%b x=%h c=%b want v=1 x=%h c=1", i, out_valid, x_out, c_out, 4'(i + 3));
            end
        end
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [3:0] xs [4];
        logic       cs [4];
        logic [2:0] ns [4];
        xs = '{4'h5, 4'h6, 4'h7, 4'h8};
        cs = '{1'b0, 1'b0, 1'b1, 1'b1};
        ns = '{3'd2, 3'd2, 3'd1, 3'd0};
        do_reset();
        in_valid = 1'b1;
        in_data = 4'h5; cycle();
        in_data = 4'h6; cycle();
        total++;
        if (count !== 3'd2) begin
            bad++;
            $display("[TB] FAIL simul_setup got count=%0d want count=2", count);
        end
        ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = (i < 2);
            in_data  = 4'(7 + i);
            if (i == 2) ready_b = 1'b1;
            cycle();
            total++;
            if (obs !== want || out_valid !== 1'b1 || x_out !== xs[i] || c_out !== cs[i] || count !== ns[i]) begin
                bad++;
                $display("[TB] FAIL simul%0d got v=%b x=%h c=%b count=%0d want v=1 x=%h c=%b count=%0d", i, out_valid, x_out, c_out, count, xs[i], cs[i], ns[i]);
            end
        end
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(10 + i);
            cycle();
        end
        in_valid = 1'b0;
        ready_a  = 1'b1;
        cycle();
        total++;
        if (obs !== want || x_out !== 4'hA || count !== 3'd3) begin
            bad++;
            $display("[TB] FAIL midrst_pre got=%h want=%h", obs, want);
        end
        ready_a = 1'b0;
        #3 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, x_out, c_out, count, in_ready} !== {1'b0, 4'h0, 1'b0, 3'd0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL midrst_async got=%h want=%h", {out_valid, x_out, c_out, count, in_ready}, {1'b0, 4'h0, 1'b0, 3'd0, 1'b1});
        end
        model_reset();
        ready_a = 1'b1;
        ready_b = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("[TB] FAIL midrst_held got v=%b count=%0d want v=0 count=0", out_valid, count);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'hF;
        cycle();
        in_valid = 1'b0;
        total++;
        if (obs !== want || out_valid !== 1'b0 || count !== 3'd1) begin
            bad++;
            $display("[TB] FAIL midrst_push got=%h want=%h", obs, want);
        end
        cycle();
        total++;
        if (obs !== want || {out_valid, x_out, c_out} !== {1'b1, 4'hF, 1'b0}) begin
            bad++;
            $display("[TB] FAIL midrst_new got v=%b x=%h c=%b want v=1 x=f c=0", out_valid, x_out, c_out);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (obs !== want || out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midrst_stale%0d got v=%b x=%h want v=0 x=0", i, out_valid, x_out);
            end
        end
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_burst();
        test_full();
        test_stall();
        test_simultaneous();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
